// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and instruction field positions for the MIPS core.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } fetch_state_e;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus; the fetch stage is master, memory is slave.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: resets to RESET_PC, steps by one word, or loads a word-aligned target.
module fetch_unit_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] load_pc_i,
    input  logic               inc_i,
    output logic [INSTR_W-1:0] pc_o
);

    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] pc_d;

    // A load beats an increment so a redirect always lands on its target.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, registered output slot to decode.
// Define FETCH_DELAY_SLOT_EN to keep the sequential instruction after a redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    output logic               if_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc,
    output logic [INSTR_W-1:0] if_pc_plus4,
    output logic [5:0]         if_opcode,
    output logic [5:0]         if_func
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DelaySlotEn = 1'b1;
`else
    localparam bit DelaySlotEn = 1'b0;
`endif

    fetch_state_e       state_q;
    logic               stale_q;
    logic               imem_req_q;
    logic [INSTR_W-1:0] imem_addr_q;
    logic               if_valid_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [INSTR_W-1:0] if_pc_q;
    logic               ds_pending_q;
    logic [INSTR_W-1:0] ds_target_q;

    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] redirect_aligned;
    logic               accept;
    logic               squash;
    logic               deliver;
    logic               hold_slot;
    logic               pc_load;
    logic [INSTR_W-1:0] pc_load_val;

    assign redirect_aligned = word_align(redirect_pc);
    assign accept    = if_valid_q && id_ready;
    assign squash    = redirect_valid && !DelaySlotEn;
    assign deliver   = (state_q == ST_WAIT) && imem.imem_rvalid && !stale_q && !squash;
    // Delay slot already sitting unaccepted in the output register: jump right away.
    assign hold_slot = redirect_valid && DelaySlotEn && if_valid_q && !accept;

    // Otherwise the delay-slot word still has to arrive; the target is applied when it does.
    always_comb begin
        pc_load     = squash || hold_slot;
        pc_load_val = redirect_aligned;
        if (DelaySlotEn && deliver && (redirect_valid || ds_pending_q)) begin
            pc_load     = 1'b1;
            pc_load_val = redirect_valid ? redirect_aligned : ds_target_q;
        end
    end

    fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pc_load),
        .load_pc_i (pc_load_val),
        .inc_i     (deliver),
        .pc_o      (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            stale_q      <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= RESET_PC;
            ds_pending_q <= 1'b0;
            ds_target_q  <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!squash) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Request stays up with its original address until memory answers.
                    if (imem.imem_rvalid) begin
                        imem_req_q <= 1'b0;
                        stale_q    <= 1'b0;
                        if (deliver) begin
                            if_instr_q <= imem.imem_rdata;
                            if_pc_q    <= imem_addr_q;
                            if_valid_q <= 1'b1;
                            state_q    <= ST_FULL;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (squash) begin
                        stale_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept || squash) begin
                        if_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (deliver) begin
                ds_pending_q <= 1'b0;
            end else if (redirect_valid && DelaySlotEn && !hold_slot) begin
                ds_pending_q <= 1'b1;
                ds_target_q  <= redirect_aligned;
            end
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc_q + 32'd4;
    assign if_opcode      = if_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign if_func        = if_instr_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS CPU, sitting directly upstream of the controller and decode logic. It owns the program counter, requests instruction words from instruction memory over a single-outstanding request/response handshake, and holds each fetched word in an output register with a valid/ready handshake to decode. It accepts PC redirects from branch/jump resolution and squashes stale fetches, with optional MIPS branch-delay-slot semantics.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_rvalid
- imem_addr  out  32  word-aligned fetch address; stable while imem_req high
- imem_rvalid  in  1  response valid; one cycle per request, ≥1 cycle after imem_req rises
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- redirect_valid  in  1  one-cycle pulse: change PC
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
- if_valid  out  1  if_instr/if_pc hold a live instruction
- id_ready  in  1  decode accepts when if_valid && id_ready
- if_instr  out  32  instruction word
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32
- if_opcode  out  6  if_instr[31:26], feeds controller opcode
- if_func  out  6  if_instr[5:0], feeds controller func

## Operation
- States: IDLE, WAIT (request outstanding), FULL (output register occupied, no request outstanding).
- IDLE: drive imem_req=1, imem_addr=pc; go WAIT.
- WAIT: on imem_rvalid, if response not stale, load if_instr=imem_rdata, if_pc=imem_addr, pc=imem_addr+4, if_valid=1, go FULL; if stale, discard, go IDLE.
- FULL: when accepted (if_valid && id_ready), clear if_valid, go IDLE. Accept and new request never overlap: one instruction per 3 cycles minimum with 1-cycle memory.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Redirect (no delay slot): pc=redirect_pc; if_valid cleared same edge; an in-flight request is marked stale (imem_req stays high with old address until rvalid, then dropped); state -> IDLE (or WAIT with stale flag).
- Redirect coinciding with acceptance: acceptance counts; redirect still applied.
- Redirect coinciding with imem_rvalid: returned word is stale, discarded.
- Two redirects before stale response returns: last redirect_pc wins; one stale response dropped.
- rst mid-request: state IDLE, stale flag cleared; a subsequent imem_rvalid for the aborted request is ignored while in IDLE.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, if_opcode=0, if_func=0.
- Cycle 1 after rst falls: imem_req=1, imem_addr=RESET_PC.
- if_valid rises the cycle after imem_rvalid (registered); if_opcode/if_func are combinational slices of if_instr.
- All outputs registered except if_opcode/if_func/if_pc_plus4 (derived from registers).

## Configuration
- FETCH_DELAY_SLOT_EN defined: on redirect, the next sequential instruction after the branch is kept: if if_valid is high and not accepted that cycle, it is kept and delivered; else if a request is in flight to branch_pc+4, its response is kept; else the sequential word is fetched before switching to redirect_pc. Exactly one delay-slot instruction delivered per redirect, then fetch continues at redirect_pc.
- Undefined: all unaccepted and in-flight instructions squashed as above; no delay slot.

## Structure
- Shared package cpu_pkg: fetch state enum (IDLE/WAIT/FULL), OPCODE_MSB/LSB, FUNC_MSB/LSB field constants, instruction width 32.
- One sub-module natural: pc_reg (PC register with reset to RESET_PC, +4 increment, redirect load).

## Test plan
- Reset, memory 1-cycle latency, id_ready=1: addresses 0x0, 0x4, 0x8 requested; if_pc sequence matches, if_opcode/if_func equal word slices.
- id_ready=0 for 5 cycles with if_valid=1: if_instr/if_pc stable, imem_req stays 0; release -> next fetch at if_pc+4.
- Redirect to 0x100 while request to 0x8 outstanding (latency 3): 0x8 word dropped, next if_pc=0x100 (macro off); with FETCH_DELAY_SLOT_EN, 0x8 delivered then 0x100.
- Redirect coincident with imem_rvalid: word discarded, next if_pc=redirect_pc (macro off).
- PC at 0xFFFF_FFFC: next fetch address 0x0000_0000, if_pc_plus4=0x0.
- rst asserted in WAIT, stale rvalid arrives cycle after rst falls: ignored; first delivered if_pc=RESET_PC.
